// File: rtl/weight_fetch_rd_if.sv
// weight_fetch_rd_if: AXI4 read address/data channels between the weight fetcher and memory
interface weight_fetch_rd_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  modport master(output araddr, arlen, arsize, arburst, arvalid, rready,
                 input arready, rdata, rresp, rlast, rvalid);
  modport slave(input araddr, arlen, arsize, arburst, arvalid, rready,
                output arready, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/weight_fetch_rd.sv
// weight_fetch_rd: AXI4 read master fetching 9 kernel + 2 BN words per filter for the conv/BN engine
module weight_fetch_rd #(
  parameter int ADDR_W  = 32,
  parameter int FILT_W  = 10,
  parameter int KWORDS  = 9,
  parameter int BNWORDS = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              soft_rst,
  input  logic              bn_en,
  input  logic [ADDR_W-1:0] wsadr1,
  input  logic [ADDR_W-1:0] wsadr2,
  input  logic [FILT_W-1:0] num_filt,
  input  logic              start,
  input  logic              next,
  output logic              ready,
  output logic [31:0]       data00, data01, data02,
  output logic [31:0]       data10, data11, data12,
  output logic [31:0]       data20, data21, data22,
  output logic [31:0]       bn0, bn1,
  output logic              done,
  output logic              err,
  weight_fetch_rd_if.master m_axi
);
  typedef enum logic [2:0] {IDLE, AR_K, R_K, AR_B, R_B, HOLD, REL, FIN} state_t;
  state_t state, state_n;
  logic              start_q;
  logic [ADDR_W-1:0] kptr, bptr, ptr;
  logic [FILT_W-1:0] fcnt;
  logic [3:0]        wcnt, total, left, beats;
  logic [10:0]       to4k;
  logic [31:0]       kw [KWORDS];
  logic [31:0]       bw [BNWORDS];
  logic              is_k, rx, more, start_edge;
  // Burst length is capped so no burst crosses a 4KB page
  always_comb begin
    start_edge = start & ~start_q;
    is_k       = (state == AR_K) || (state == R_K);
    ptr        = is_k ? kptr : bptr;
    total      = is_k ? 4'(KWORDS) : 4'(BNWORDS);
    left       = total - wcnt;
    to4k       = 11'd1024 - {1'b0, ptr[11:2]};
    beats      = ({7'd0, left} < to4k) ? left : to4k[3:0];
    rx         = ((state == R_K) || (state == R_B)) && m_axi.rvalid;
    more       = (wcnt + 4'd1) < total;
  end
  assign m_axi.araddr  = ptr;
  assign m_axi.arlen   = {4'd0, beats - 4'd1};
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = (state == AR_K) || (state == AR_B);
  assign m_axi.rready  = (state == R_K) || (state == R_B);
  assign ready = state == HOLD;
  assign {data00, data01, data02, data10, data11, data12, data20, data21, data22} =
         {kw[0], kw[1], kw[2], kw[3], kw[4], kw[5], kw[6], kw[7], kw[8]};
  assign {bn0, bn1} = {bw[0], bw[1]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: if (start_edge) state_n = (num_filt == '0) ? FIN : AR_K;
      AR_K:      if (m_axi.arready) state_n = R_K;
      R_K:       if (rx && m_axi.rlast) state_n = more ? AR_K : bn_en ? AR_B : HOLD;
      AR_B:      if (m_axi.arready) state_n = R_B;
      R_B:       if (rx && m_axi.rlast) state_n = more ? AR_B : HOLD;
      HOLD:      if (next) state_n = REL;
      REL:       if (!next) state_n = (fcnt == '0) ? FIN : AR_K;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= soft_rst ? IDLE : state_n;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      start_q <= 1'b0;
      kptr    <= '0;
      bptr    <= '0;
      fcnt    <= '0;
      wcnt    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      kw      <= '{default: '0};
      bw      <= '{default: '0};
    end else if (soft_rst) begin
      start_q <= 1'b0;
      kptr    <= '0;
      bptr    <= '0;
      fcnt    <= '0;
      wcnt    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      kw      <= '{default: '0};
      bw      <= '{default: '0};
    end else begin
      start_q <= start;
      if (((state == IDLE) || (state == FIN)) && start_edge) begin
        kptr <= wsadr1;
        bptr <= wsadr2;
        fcnt <= num_filt;
        wcnt <= '0;
        done <= num_filt == '0;
        err  <= 1'b0;
      end
      if (rx) begin
        if (is_k) kw[wcnt] <= m_axi.rdata;
        else bw[wcnt[0]] <= m_axi.rdata;
        if (is_k) kptr <= kptr + ADDR_W'(4);
        else bptr <= bptr + ADDR_W'(4);
        wcnt <= (m_axi.rlast && !more) ? 4'd0 : wcnt + 4'd1;
        if (m_axi.rresp != 2'b00) err <= 1'b1;
        if (m_axi.rlast && !more && is_k && !bn_en) bw <= '{default: '0};
      end
      if ((state == HOLD) && next) fcnt <= fcnt - 1'b1;
      if ((state == REL) && !next && (fcnt == '0)) done <= 1'b1;
    end
  end
endmodule
